// File: rtl/bus_owner_arbiter.sv
// Shared-bus ownership arbiter: strongest priority wins, ties rotate round-robin,
// and each hand-over is padded by setup and turnaround cycles with no driver enabled.
module bus_owner_arbiter #(
  parameter int N        = 4,
  parameter int PRIO_W   = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*PRIO_W-1:0]   prio,
  input  logic [N-1:0]          done,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          drive_en,
  output logic [$clog2(N)-1:0]  owner,
  output logic                  busy,
  output logic                  preempt
);

  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    owner_r, owner_s, last_owner_r, win_s;
  logic [PRIO_W-1:0]   owner_prio_r, owner_prio_s, best_prio_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic                found_s, take_s, stronger_s, rival_s, release_s, preempt_s;
  logic                other_s;
  int                  idx_s;
  logic [N-1:0]        gnt_r, drive_en_r;
  logic                busy_r, preempt_r;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Winner search: scan upward from the slot after last_owner; strict '>' keeps the first tie.
  always_comb begin
    win_s       = last_owner_r;
    best_prio_s = '0;
    found_s     = 1'b0;
    take_s      = 1'b0;
    idx_s       = 0;
    for (int k = 1; k <= N; k++) begin
      idx_s       = (int'(last_owner_r) + k) % N;
      take_s      = req[idx_s] && (!found_s || (prio[idx_s*PRIO_W +: PRIO_W] > best_prio_s));
      found_s     = found_s | take_s;
      best_prio_s = take_s ? prio[idx_s*PRIO_W +: PRIO_W] : best_prio_s;
      win_s       = take_s ? IDX_W'(idx_s) : win_s;
    end
  end

  // Challengers to the current owner, judged against its priority frozen at grant time.
  always_comb begin
    stronger_s = 1'b0;
    rival_s    = 1'b0;
    other_s    = 1'b0;
    for (int j = 0; j < N; j++) begin
      other_s    = req[j] && (IDX_W'(j) != owner_r);
      stronger_s = stronger_s | (other_s && (prio[j*PRIO_W +: PRIO_W] >  owner_prio_r));
      rival_s    = rival_s    | (other_s && (prio[j*PRIO_W +: PRIO_W] >= owner_prio_r));
    end
    release_s = !req[owner_r] || done[owner_r];
  end

  // Next-state and datapath updates; a normal release outranks any preemption.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    owner_prio_s = owner_prio_r;
    hold_cnt_s   = '0;
    preempt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s      = GRANT;
          owner_s      = win_s;
          owner_prio_s = best_prio_s;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s = RELEASE;
        end else begin
          state_s    = OWN;
          hold_cnt_s = HOLD_ONE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_s = RELEASE;
        end else if (stronger_s || ((hold_cnt_r == HOLD_MAX) && rival_s)) begin
          state_s   = RELEASE;
          preempt_s = 1'b1;
        end else begin
          state_s    = OWN;
          hold_cnt_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + HOLD_ONE;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state and ownership bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      last_owner_r <= IDX_W'(N - 1);
      owner_prio_r <= '0;
      hold_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      owner_prio_r <= owner_prio_s;
      hold_cnt_r   <= hold_cnt_s;
      if (state_r == RELEASE) begin
        last_owner_r <= owner_r;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r      <= '0;
      drive_en_r <= '0;
      busy_r     <= 1'b0;
      preempt_r  <= 1'b0;
    end else begin
      gnt_r      <= ((state_s == GRANT) || (state_s == OWN)) ? onehot(owner_s) : '0;
      drive_en_r <= (state_s == OWN) ? onehot(owner_s) : '0;
      busy_r     <= (state_s != IDLE);
      preempt_r  <= preempt_s;
    end
  end

  assign gnt      = gnt_r;
  assign drive_en = drive_en_r;
  assign owner    = owner_r;
  assign busy     = busy_r;
  assign preempt  = preempt_r;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Bench for bus_owner_arbiter: per-cycle vector table through a scoreboard queue,
// hand-written reset / round-robin sequences, and a randomised invariant run.
module tb_bus_owner_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, done, gnt, drive_en;
  logic [7:0] prio;
  logic [1:0] owner;
  logic       busy, preempt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] prio;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [3:0] drv;
    logic [1:0] own;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vec_q[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  bus_owner_arbiter #(.N(4), .PRIO_W(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .prio(prio), .done(done),
    .gnt(gnt), .drive_en(drive_en), .owner(owner), .busy(busy), .preempt(preempt)
  );

  function automatic logic [7:0] pk(input logic [1:0] p3, input logic [1:0] p2,
                                    input logic [1:0] p1, input logic [1:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [7:0] p, input logic [3:0] d,
                              input logic [3:0] g, input logic [3:0] e, input logic [1:0] o,
                              input logic b, input logic pr);
    vec_t v;
    v.req = r; v.prio = p; v.done = d; v.gnt = g; v.drv = e; v.own = o; v.busy = b; v.pre = pr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    req = v.req; prio = v.prio; done = v.done;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("v%0d_gnt", idx),     8'(gnt),      8'(e.gnt));
    chk($sformatf("v%0d_drive_en", idx), 8'(drive_en), 8'(e.drv));
    chk($sformatf("v%0d_owner", idx),   8'(owner),    8'(e.own));
    chk($sformatf("v%0d_busy", idx),    8'(busy),     8'(e.busy));
    chk($sformatf("v%0d_preempt", idx), 8'(preempt),  8'(e.pre));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},      8'(gnt),      8'h00);
    chk({tag, "_drive_en"}, 8'(drive_en), 8'h00);
    chk({tag, "_busy"},     8'(busy),     8'h00);
    chk({tag, "_preempt"},  8'(preempt),  8'h00);
    chk({tag, "_owner"},    8'(owner),    8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pa, ps, pw, pb, pi, pe, pd;
    logic [3:0] prev_gnt, prev_drv;
    logic       ok;

    pa = pk(2'd0, 2'd1, 2'd0, 2'd0);
    ps = pk(2'd0, 2'd0, 2'd3, 2'd1);
    pw = pk(2'd0, 2'd2, 2'd3, 2'd1);
    pb = pk(2'd3, 2'd2, 2'd3, 2'd1);
    pi = pk(2'd0, 2'd3, 2'd0, 2'd0);
    pe = pk(2'd0, 2'd3, 2'd0, 2'd3);
    pd = pk(2'd0, 2'd0, 2'd2, 2'd0);

    // single requester 2 (last_owner = 3 after reset)
    vec_q.push_back(mk(4'b0100, pa, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0100, pa, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0100, pa, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0100, pa, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, pa, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
    // strength wins, weaker newcomer ignored, equal newcomer waits for MAX_HOLD
    vec_q.push_back(mk(4'b0011, ps, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0011, ps, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0111, pw, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++)
      vec_q.push_back(mk(4'b1111, pb, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b1111, pb, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1));
    vec_q.push_back(mk(4'b1111, pb, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
    vec_q.push_back(mk(4'b1111, pb, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b1111, pb, 4'b0000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b1000, pb, 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, pb, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0));
    // immediate preemption of a prio-0 owner, then equal rival and stray done are ignored
    vec_q.push_back(mk(4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0101, pi, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1));
    vec_q.push_back(mk(4'b0101, pi, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
    vec_q.push_back(mk(4'b0101, pi, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0101, pi, 4'b0000, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0101, pe, 4'b0001, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0100, pe, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, pe, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
    // done coinciding with a stronger challenger is a plain release
    vec_q.push_back(mk(4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0001, 8'h00, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0011, pd, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0010, pd, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
    vec_q.push_back(mk(4'b0010, pd, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0010, pd, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0010, pd, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, pd, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
    // withdrawal and done during GRANT skip OWN entirely
    vec_q.push_back(mk(4'b0100, 8'h00, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
    vec_q.push_back(mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
    vec_q.push_back(mk(4'b1000, 8'h00, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b1000, 8'h00, 4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0));
    // requester 1 takes the bus ahead of the asynchronous reset
    vec_q.push_back(mk(4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0));
    vec_q.push_back(mk(4'b0010, 8'h00, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));

    rst_n = 1'b0; req = '0; prio = '0; done = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vec_q.size(); i++) apply(vec_q[i], i);

    // Reset mid-ownership must clear outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk);
    req = 4'b1111; prio = pk(2'd2, 2'd2, 2'd2, 2'd2); done = '0;
    rst_n = 1'b1;

    // Equal priorities rotate 0,1,2,3,0 with a three-cycle driver gap.
    for (int o = 0; o < 5; o++) begin
      apply(mk(4'b1111, prio, 4'b0000, oh(o % 4), 4'b0000,  2'(o % 4), 1'b1, 1'b0), 100 + o*5);
      apply(mk(4'b1111, prio, 4'b0000, oh(o % 4), oh(o % 4), 2'(o % 4), 1'b1, 1'b0), 101 + o*5);
      apply(mk(4'b1111, prio, 4'b0000, oh(o % 4), oh(o % 4), 2'(o % 4), 1'b1, 1'b0), 102 + o*5);
      apply(mk(4'b1111, prio, oh(o % 4), 4'b0000, 4'b0000,  2'(o % 4), 1'b1, 1'b0), 103 + o*5);
      apply(mk(4'b1111, prio, 4'b0000, 4'b0000, 4'b0000,    2'(o % 4), 1'b0, 1'b0), 104 + o*5);
    end

    prev_gnt = gnt;
    prev_drv = drive_en;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) prio = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      @(negedge clk);
      ok = ($countones(gnt) <= 1) && ($countones(drive_en) <= 1)
        && ((drive_en == 4'b0000) || (gnt == drive_en))
        && ((drive_en == 4'b0000) || (prev_drv == drive_en)
            || ((prev_drv == 4'b0000) && (prev_gnt == drive_en)))
        && ((drive_en == 4'b0000) || busy)
        && (!preempt || ((gnt == 4'b0000) && (drive_en == 4'b0000) && busy));
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL invariant c%0d: gnt=%b drive_en=%b prev_gnt=%b prev_drive_en=%b busy=%b preempt=%b",
                    c, gnt, drive_en, prev_gnt, prev_drv, busy, preempt);
      prev_gnt = gnt;
      prev_drv = drive_en;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
